// File: rtl/loader_pkg.sv
// Shared definitions for the UART loader / memory dump pair: protocol bytes, widths
// and the dump engine state encoding.
package loader_pkg;

  localparam int unsigned SIZE_W     = 16;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [7:0] ACK_LOAD = 8'hF1;
  localparam logic [7:0] ACK_DUMP = 8'hF2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SIZE_HI,
    S_SIZE_LO,
    S_CHECK,
    S_READ,
    S_WAIT_MEM,
    S_LATCH,
    S_SEND_BYTE,
    S_WAIT_TX,
    S_SEND_END,
    S_WAIT_END,
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/memory_dump_unit_serializer.sv
// Word-to-byte serializer: holds one memory word and presents it LSB-first, one byte
// per advance strobe, flagging the final byte of the word.
module word_serializer
  import loader_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      advance_i,
  input  logic [8*WORD_BYTES-1:0]   word_i,
  output logic [7:0]                byte_o,
  output logic                      last_o
);

  localparam int unsigned IdxW = $clog2(WORD_BYTES);

  logic [8*WORD_BYTES-1:0] r_shift;
  logic [IdxW-1:0]         r_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (load_i) begin
      r_shift <= word_i;
      r_idx   <= '0;
    end else if (advance_i) begin
      r_shift <= r_shift >> 8;
      r_idx   <= r_idx + 1'b1;
    end
  end

  assign byte_o = r_shift[7:0];
  assign last_o = (r_idx == IdxW'(WORD_BYTES - 1));

endmodule

// File: rtl/memory_dump_unit.sv
// Read-back DMA engine: receives a 16-bit word count over UART, streams that many memory
// words out LSB-first over UART TX, then sends a trailer byte and reports done.
module memory_dump_unit
  import loader_pkg::*;
#(
  parameter logic [7:0]  END_BYTE    = ACK_DUMP,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        grant_i,
  input  logic        target_select_i,
  output logic        done_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  output logic        mem_read_enable_o,
  output logic        mem_target_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i
);

  dump_state_t       r_state, w_state_next;
  logic [SIZE_W-1:0] r_size;
  logic [SIZE_W-1:0] r_count;
  logic              r_target;
  logic [31:0]       r_addr;

  logic       w_abort;
  logic       w_load;
  logic       w_advance;
  logic [7:0] w_byte;
  logic       w_last;

  // Losing the grant mid-transfer abandons the dump without a trailer.
  assign w_abort = !grant_i && (r_state != S_IDLE) && (r_state != S_DONE);

  assign w_load    = (r_state == S_LATCH);
  assign w_advance = (r_state == S_WAIT_TX) && tx_done_i;

  word_serializer u_serializer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (w_load),
    .advance_i (w_advance),
    .word_i    (mem_data_i),
    .byte_o    (w_byte),
    .last_o    (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_size   <= '0;
      r_count  <= '0;
      r_target <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && grant_i) begin
        r_target <= target_select_i;
      end
      if (!w_abort) begin
        if (r_state == S_SIZE_HI && rx_ready_i) begin
          r_size[15:8] <= rx_data_i;
        end
        if (r_state == S_SIZE_LO && rx_ready_i) begin
          r_size[7:0] <= rx_data_i;
          r_count     <= '0;
        end
        // Address is captured on the way into S_READ and then held.
        if (r_state == S_CHECK && r_count != r_size) begin
          r_addr <= {{(32 - SIZE_W){1'b0}}, r_count};
        end
        if (w_advance && w_last) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:      if (grant_i) w_state_next = S_SIZE_HI;
      S_SIZE_HI:   if (rx_ready_i) w_state_next = S_SIZE_LO;
      S_SIZE_LO:   if (rx_ready_i) w_state_next = S_CHECK;
      S_CHECK:     w_state_next = (r_count == r_size) ? S_SEND_END : S_READ;
      S_READ:      w_state_next = (MEM_LATENCY > 1) ? S_WAIT_MEM : S_LATCH;
      S_WAIT_MEM:  w_state_next = S_LATCH;
      S_LATCH:     w_state_next = S_SEND_BYTE;
      S_SEND_BYTE: w_state_next = S_WAIT_TX;
      S_WAIT_TX:   if (tx_done_i) w_state_next = w_last ? S_CHECK : S_SEND_BYTE;
      S_SEND_END:  w_state_next = S_WAIT_END;
      S_WAIT_END:  if (tx_done_i) w_state_next = S_DONE;
      S_DONE:      if (!grant_i) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_next = S_IDLE;
    end
  end

  always_comb begin
    done_o            = (r_state == S_DONE);
    tx_start_o        = (r_state == S_SEND_BYTE) || (r_state == S_SEND_END);
    mem_read_enable_o = (r_state == S_READ);
    mem_target_o      = r_target;
    mem_addr_o        = r_addr;
    tx_data_o         = 8'h00;
    if (r_state == S_SEND_BYTE || r_state == S_WAIT_TX) begin
      tx_data_o = w_byte;
    end else if (r_state == S_SEND_END || r_state == S_WAIT_END) begin
      tx_data_o = END_BYTE;
    end
  end

endmodule

// File: tb/tb_memory_dump_unit.sv
// Scoreboard bench for memory_dump_unit: one instance at memory latency 1, one at 2.
module tb_memory_dump_unit;
  import loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        grant_a, grant_b, target;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        inj_done;

  logic        done_a, tx_start_a, tx_done_a, re_a, tgt_a;
  logic [7:0]  tx_data_a;
  logic [31:0] addr_a, rdata_a;
  logic        done_b, tx_start_b, tx_done_b, re_b, tgt_b;
  logic [7:0]  tx_data_b;
  logic [31:0] addr_b, rdata_b, pipe_b;

  logic [31:0] mem [0:3];

  memory_dump_unit #(.END_BYTE(8'hF2), .MEM_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .grant_i(grant_a), .target_select_i(target), .done_o(done_a),
    .rx_data_i(rx_data), .rx_ready_i(rx_ready), .tx_data_o(tx_data_a), .tx_start_o(tx_start_a),
    .tx_done_i(tx_done_a | inj_done), .mem_read_enable_o(re_a), .mem_target_o(tgt_a),
    .mem_addr_o(addr_a), .mem_data_i(rdata_a)
  );

  memory_dump_unit #(.END_BYTE(8'hF2), .MEM_LATENCY(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .grant_i(grant_b), .target_select_i(target), .done_o(done_b),
    .rx_data_i(rx_data), .rx_ready_i(rx_ready), .tx_data_o(tx_data_b), .tx_start_o(tx_start_b),
    .tx_done_i(tx_done_b), .mem_read_enable_o(re_b), .mem_target_o(tgt_b),
    .mem_addr_o(addr_b), .mem_data_i(rdata_b)
  );

  // Memory models: data only valid exactly MEM_LATENCY cycles after the read strobe.
  always @(posedge clk) rdata_a <= re_a ? mem[addr_a[1:0]] : 32'h0BAD_0BAD;
  always @(posedge clk) begin
    pipe_b  <= re_b ? mem[addr_b[1:0]] : 32'h0BAD_0BAD;
    rdata_b <= pipe_b;
  end

  // UART TX models: done strobe three cycles after each start.
  int cnt_a, cnt_b;
  always @(posedge clk) begin
    tx_done_a <= 1'b0;
    if (rst) cnt_a <= 0;
    else if (tx_start_a) cnt_a <= 3;
    else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) tx_done_a <= 1'b1;
    end
  end
  always @(posedge clk) begin
    tx_done_b <= 1'b0;
    if (rst) cnt_b <= 0;
    else if (tx_start_b) cnt_b <= 3;
    else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) tx_done_b <= 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] addr_q[$];
  bit          long_pulse, timed_out;

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic release_grant();
    @(negedge clk);
    grant_a = 1'b0;
    grant_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Records TX bytes and read addresses until done_o or the cycle budget expires.
  task automatic collect(input bit sel_b, input bit spur_rx, input int max_cyc);
    bit s_start, s_re, s_done, prev_re, spur_next;
    logic [7:0]  s_data;
    logic [31:0] s_addr;
    got_q.delete();
    addr_q.delete();
    long_pulse = 1'b0;
    timed_out  = 1'b1;
    prev_re    = 1'b0;
    spur_next  = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      rx_ready = 1'b0;
      if (spur_next) begin
        rx_data   = 8'h55;
        rx_ready  = 1'b1;
        spur_next = 1'b0;
      end
      s_start = sel_b ? tx_start_b : tx_start_a;
      s_data  = sel_b ? tx_data_b : tx_data_a;
      s_re    = sel_b ? re_b : re_a;
      s_addr  = sel_b ? addr_b : addr_a;
      s_done  = sel_b ? done_b : done_a;
      if (s_start) begin
        if (spur_rx && got_q.size() == 0) spur_next = 1'b1;
        got_q.push_back(s_data);
      end
      if (s_re) begin
        if (prev_re) long_pulse = 1'b1;
        addr_q.push_back(s_addr);
      end
      prev_re = s_re;
      if (s_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done_a); end
    n_tests++; if (tx_start_a !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %0b want 0", tx_start_a); end
    n_tests++; if (re_a !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re got %0b want 0", re_a); end
    n_tests++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr_a); end
    n_tests++; if (done_b !== 1'b0 || addr_b !== 32'h0) begin
      n_fail++; $display("FAIL reset_b got done=%0b addr=%h want 0/0", done_b, addr_b);
    end
  endtask

  task automatic test_two_word(input bit spurious);
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEBABE;
    exp_q.delete();
    push_word(32'hDEADBEEF);
    push_word(32'hCAFEBABE);
    exp_q.push_back(8'hF2);
    @(negedge clk);
    target  = 1'b1;
    grant_a = 1'b1;
    if (spurious) begin
      @(negedge clk);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
    end
    send_rx(8'h00);
    send_rx(8'h02);
    collect(1'b0, spurious, 400);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL two_word_timeout sp=%0b got no done want done", spurious); end
    n_tests++; if (got_q.size() != 9) begin
      n_fail++; $display("FAIL two_word_len sp=%0b got %0d want 9", spurious, got_q.size());
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (got_q[i] !== e) begin n_fail++; $display("FAIL two_word_byte%0d sp=%0b got %h want %h", i, spurious, got_q[i], e); end
    end
    n_tests++; if (addr_q.size() != 2 || addr_q[0] !== 32'd0 || addr_q[1] !== 32'd1) begin
      n_fail++; $display("FAIL two_word_addr sp=%0b got n=%0d want 0,1", spurious, addr_q.size());
    end
    n_tests++; if (tgt_a !== 1'b1) begin n_fail++; $display("FAIL two_word_target got %0b want 1", tgt_a); end
    n_tests++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL two_word_done got %0b want 1", done_a); end
    grant_a = 1'b0;
    @(negedge clk);
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL two_word_done_drop got %0b want 0", done_a); end
    release_grant();
  endtask

  task automatic test_zero_size();
    exp_q.delete();
    exp_q.push_back(8'hF2);
    @(negedge clk);
    target  = 1'b0;
    grant_a = 1'b1;
    send_rx(8'h00);
    send_rx(8'h00);
    collect(1'b0, 1'b0, 100);
    n_tests++; if (timed_out || done_a !== 1'b1) begin n_fail++; $display("FAIL zero_done got %0b want 1", done_a); end
    n_tests++; if (addr_q.size() != 0) begin n_fail++; $display("FAIL zero_reads got %0d want 0", addr_q.size()); end
    n_tests++; if (got_q.size() != 1 || got_q[0] !== exp_q.pop_front()) begin
      n_fail++; $display("FAIL zero_tx got n=%0d want single F2", got_q.size());
    end
    release_grant();
  endtask

  task automatic test_abort();
    int starts, extra;
    bit  saw_done;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEBABE;
    @(negedge clk);
    target  = 1'b0;
    grant_a = 1'b1;
    send_rx(8'h00);
    send_rx(8'h02);
    starts = 0;
    for (int c = 0; c < 200 && starts < 2; c++) begin
      @(negedge clk);
      if (tx_start_a) starts++;
    end
    n_tests++; if (starts != 2) begin n_fail++; $display("FAIL abort_reach got %0d starts want 2", starts); end
    grant_a = 1'b0;
    @(negedge clk);
    n_tests++; if (dut_a.r_state !== S_IDLE) begin
      n_fail++; $display("FAIL abort_idle got %0d want %0d", dut_a.r_state, S_IDLE);
    end
    extra = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (tx_start_a) extra++;
      if (done_a) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL abort_no_tx got %0d starts want 0", extra); end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL abort_done got 1 want 0"); end
    // A fresh one-word dump must still start from address 0.
    mem[0] = 32'h12345678;
    exp_q.delete();
    push_word(32'h12345678);
    exp_q.push_back(8'hF2);
    grant_a = 1'b1;
    send_rx(8'h00);
    send_rx(8'h01);
    collect(1'b0, 1'b0, 200);
    n_tests++; if (timed_out || got_q.size() != 5) begin
      n_fail++; $display("FAIL abort_redo_len got %0d want 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (got_q[i] !== e) begin n_fail++; $display("FAIL abort_redo_byte%0d got %h want %h", i, got_q[i], e); end
    end
    n_tests++; if (addr_q.size() != 1 || addr_q[0] !== 32'd0 || tgt_a !== 1'b0) begin
      n_fail++; $display("FAIL abort_redo_addr got n=%0d tgt=%0b want addr 0 tgt 0", addr_q.size(), tgt_a);
    end
    release_grant();
  endtask

  task automatic test_latency2();
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'hCAFEBABE;
    exp_q.delete();
    push_word(32'hDEADBEEF);
    push_word(32'hCAFEBABE);
    exp_q.push_back(8'hF2);
    @(negedge clk);
    target  = 1'b1;
    grant_b = 1'b1;
    send_rx(8'h00);
    send_rx(8'h02);
    collect(1'b1, 1'b0, 400);
    n_tests++; if (timed_out || got_q.size() != 9) begin
      n_fail++; $display("FAIL lat2_len got %0d want 9", got_q.size());
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (got_q[i] !== e) begin n_fail++; $display("FAIL lat2_byte%0d got %h want %h", i, got_q[i], e); end
    end
    n_tests++; if (long_pulse || addr_q.size() != 2) begin
      n_fail++; $display("FAIL lat2_read_pulse got long=%0b n=%0d want 0/2", long_pulse, addr_q.size());
    end
    n_tests++; if (tgt_b !== 1'b1) begin n_fail++; $display("FAIL lat2_target got %0b want 1", tgt_b); end
    release_grant();
  endtask

  initial begin
    rst = 1'b1; grant_a = 1'b0; grant_b = 1'b0; target = 1'b0;
    rx_data = 8'h00; rx_ready = 1'b0; inj_done = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    test_reset();
    test_two_word(1'b0);
    test_zero_size();
    test_abort();
    test_two_word(1'b1);
    test_latency2();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_dump_unit.md
Name: memory_dump_unit

Overview:
Read-back DMA engine, the counterpart of the UART loader. When the arbiter grants it the bus, it takes a 16-bit word count from the host over UART RX. It then reads that many 32-bit words from instruction or data memory, starting at word address 0, and serializes each word LSB-first onto UART TX. After the last word it sends a trailer byte and raises done_o until the grant is withdrawn.

Parameters:
END_BYTE, 8'hF2, trailer byte sent after the last data byte
MEM_LATENCY, 1, cycles from mem_read_enable_o to valid mem_data_i; supported values are 1 and 2

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
grant_i  input  1  arbiter grant; the unit is active only while this is high
target_select_i  input  1  memory select: 0 = IMEM, 1 = DMEM; sampled in S_IDLE on grant
done_o  output  1  dump complete; high in S_DONE
rx_data_i  input  8  UART RX byte
rx_ready_i  input  1  one-cycle strobe: rx_data_i is valid
tx_data_o  output  8  byte to transmit
tx_start_o  output  1  one-cycle transmit request
tx_done_i  input  1  one-cycle strobe: UART TX finished the current byte
mem_read_enable_o  output  1  memory read strobe
mem_target_o  output  1  latched target_select_i
mem_addr_o  output  32  word address, equal to the word counter
mem_data_i  input  32  read data

Behaviour:
- Reset: state S_IDLE, all outputs 0, size/count/byte index/shift register 0. Reset takes precedence over every other event.
- S_IDLE:
  - On grant_i = 1, latch target_select_i into mem_target_o and go to S_SIZE_HI next cycle.
- S_SIZE_HI:
  - On rx_ready_i, load size[15:8] from rx_data_i and go to S_SIZE_LO.
- S_SIZE_LO:
  - On rx_ready_i, load size[7:0], clear count, go to S_CHECK.
- S_CHECK:
  - If count == size, go to S_SEND_END; otherwise go to S_READ.
  - size = 0 therefore sends only the trailer.
- S_READ:
  - Assert mem_read_enable_o for exactly one cycle with mem_addr_o = {16'b0, count}.
  - Go to S_LATCH after MEM_LATENCY-1 wait cycles.
- S_LATCH:
  - Capture mem_data_i into a 32-bit shift register, clear the byte index, go to S_SEND_BYTE.
- S_SEND_BYTE:
  - Assert tx_start_o for one cycle with tx_data_o = shift[7:0], then go to S_WAIT_TX.
- S_WAIT_TX:
  - Hold tx_data_o stable.
  - On tx_done_i, shift right by 8 and increment the byte index.
  - If the byte index was 3, increment count and go to S_CHECK; otherwise go to S_SEND_BYTE.
- S_SEND_END:
  - Assert tx_start_o for one cycle with tx_data_o = END_BYTE, then go to S_WAIT_END.
- S_WAIT_END:
  - On tx_done_i, go to S_DONE.
- S_DONE:
  - done_o = 1.
  - When grant_i = 0, go to S_IDLE; done_o drops on that same transition.
- Byte order and latency:
  - Each word goes out as byte0 (bits 7:0) first and byte3 last.
  - Per-word overhead outside UART time: S_CHECK, S_READ, S_LATCH plus MEM_LATENCY-1 wait cycles.
- Abort: grant_i falling in any state other than S_IDLE/S_DONE forces S_IDLE next cycle. tx_start_o and mem_read_enable_o are 0 from that cycle on, and no trailer is sent.
- Ignored strobes:
  - rx_ready_i is ignored outside S_SIZE_HI/S_SIZE_LO.
  - tx_done_i is ignored outside S_WAIT_TX/S_WAIT_END.
  - A tx_done_i arriving in the same cycle as tx_start_o is not counted.
- Limits: count is 16 bits. The maximum size of 0xFFFF words completes without wrap; count never exceeds size.
- mem_addr_o holds its value outside S_READ. Memory writes are never issued.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum dump_state_t;
  - protocol constants ACK_LOAD = 8'hF1 and ACK_DUMP = 8'hF2;
  - the width constants SIZE_W = 16 and WORD_BYTES = 4.
- One natural sub-module, word_serializer: shift register plus byte index, with inputs load/advance and outputs byte_o/last_o. The FSM stays in memory_dump_unit.

Test Plan:
- Reset: assert rst_i for 2 cycles, then release -> done_o, tx_start_o and mem_read_enable_o all 0, mem_addr_o = 0.
- Two-word dump:
  - Stimulus: grant with target 1, RX 0x00 then 0x02; memory model returns 0xDEADBEEF at address 0 and 0xCAFEBABE at address 1; tx_done_i pulsed 3 cycles after each tx_start_o.
  - Response: TX sequence EF BE AD DE BE BA FE CA F2; mem_addr_o reads 0 then 1; mem_target_o = 1.
  - After the last tx_done_i, done_o = 1; when grant falls, done_o = 0 one cycle later.
- Zero size: RX 0x00, 0x00 -> no mem_read_enable_o pulse, a single tx byte 0xF2, then done_o = 1.
- Abort: drop grant after the second tx_start_o of a 2-word dump -> state S_IDLE next cycle, no further tx_start_o, done_o stays 0. A subsequent grant with size 1 dumps address 0 correctly.
- Spurious strobes: tx_done_i in S_SIZE_HI and rx_ready_i with 0x55 during S_WAIT_TX -> size and byte order unaffected; output matches the two-word case.
- MEM_LATENCY = 2 instance: same two-word stimulus -> identical TX byte stream; mem_read_enable_o is a single-cycle pulse per word.
